// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the round-robin CORDIC magnitude/phase scheduler.
package cordic_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int N_DEF   = 13;
   localparam int COR_LAT = N_DEF + 2;

   function automatic int ch_wdt(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // clocks from cor_st to cor_rdy for an N-iteration core
   function automatic int cor_lat(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins, pointer
// moves one past the winner whenever a grant is issued.
module cordic_rr_arb
   import cordic_sched_pkg::*;
#(
   parameter int NCH = 4,
   localparam int CH_WDT = ch_wdt(NCH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              sclr,
   input  logic [NCH-1:0]    req,
   input  logic              gnt_en,
   output logic [NCH-1:0]    gnt,
   output logic [CH_WDT-1:0] idx,
   output logic              req_any
);

   logic [CH_WDT-1:0] ptr;
   logic [CH_WDT-1:0] kk;
   logic              found;
   int                k;

   assign req_any = |req;

   // scan NCH slots starting at the pointer, wrapping once; first hit wins
   always_comb begin
      idx   = '0;
      found = 1'b0;
      k     = 0;
      kk    = '0;
      for (int i = 0; i < NCH; i++) begin
         k = int'(ptr) + i;
         if (k >= NCH) k = k - NCH;
         kk = CH_WDT'(k);
         if (!found && req[kk]) begin
            found = 1'b1;
            idx   = kk;
         end
      end
   end

   assign gnt = (gnt_en && found) ? (NCH'(1) << idx) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (sclr)
         ptr <= '0;
      else if (gnt_en && found)
         ptr <= (idx == CH_WDT'(NCH - 1)) ? '0 : idx + 1'b1;
   end

endmodule

// File: rtl/cordic_mag_ph_sched.sv
// Shares one serial CORDIC mag/phase core among NCH requesters, round-robin.
// Optional BUSY watchdog: define CORDIC_MAG_PH_SCHED_TIMEOUT_EN.
module cordic_mag_ph_sched
   import cordic_sched_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int N      = 13,
   parameter int XY_WDT = 18,
   localparam int CH_WDT = ch_wdt(NCH)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclr,
   input  logic                  en,
   input  logic [NCH-1:0]        req_vld,
   output logic [NCH-1:0]        req_rdy,
   input  logic [NCH*XY_WDT-1:0] req_x,
   input  logic [NCH*XY_WDT-1:0] req_y,
   output logic                  cor_st,
   output logic [XY_WDT-1:0]     cor_xin,
   output logic [XY_WDT-1:0]     cor_yin,
   input  logic                  cor_rdy,
   input  logic [XY_WDT-1:0]     cor_mag,
   input  logic [XY_WDT+1:0]     cor_ph,
   output logic                  res_vld,
   input  logic                  res_rdy,
   output logic [CH_WDT-1:0]     res_ch,
   output logic [XY_WDT-1:0]     res_mag,
   output logic [XY_WDT+1:0]     res_ph,
   output logic                  res_err,
   output logic                  busy
);

   if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("cordic_mag_ph_sched: NCH must be 2..16");
   end
   if (N < 1) begin : g_bad_n
      $error("cordic_mag_ph_sched: N must be >= 1");
   end

   logic [NCH-1:0][XY_WDT-1:0] xa, ya;
   assign xa = req_x;
   assign ya = req_y;

   state_t            state, nxt;
   logic              go;
   logic [NCH-1:0]    gnt;
   logic [CH_WDT-1:0] gidx;
   logic              req_any;
   logic              tmo;

   // strobes are suppressed while frozen, clearing or in reset
   assign go      = en && !sclr && !reset;
   assign req_rdy = gnt;
   assign cor_st  = go && (state == START);
   assign busy    = (state != IDLE);

   cordic_rr_arb #(.NCH(NCH)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .sclr    (sclr),
      .req     (req_vld),
      .gnt_en  (go && (state == IDLE)),
      .gnt     (gnt),
      .idx     (gidx),
      .req_any (req_any)
   );

`ifdef CORDIC_MAG_PH_SCHED_TIMEOUT_EN
   // tcnt runs 0..TO_LIM over the BUSY cycles; giving up on the last one
   localparam int TO_LIM = cor_lat(N) + 1;
   localparam int TO_W   = $clog2(TO_LIM + 1);
   logic [TO_W-1:0] tcnt;
   logic            err_q;

   assign tmo     = (state == BUSY) && !cor_rdy && (tcnt == TO_W'(TO_LIM));
   assign res_err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tcnt <= '0;
      else if (sclr)
         tcnt <= '0;
      else if (en)
         tcnt <= (state == BUSY) ? tcnt + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if (sclr)
         err_q <= 1'b0;
      else if (en) begin
         if (state == BUSY)
            err_q <= tmo;
         else if (state == HOLD && res_rdy)
            err_q <= 1'b0;
      end
   end
`else
   assign tmo     = 1'b0;
   assign res_err = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req_any) nxt = START;
         START:   nxt = BUSY;
         BUSY:    if (cor_rdy || tmo) nxt = HOLD;
         HOLD:    if (res_rdy) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else if (sclr)
         state <= IDLE;
      else if (en)
         state <= nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cor_xin <= '0;
         cor_yin <= '0;
         res_ch  <= '0;
         res_mag <= '0;
         res_ph  <= '0;
         res_vld <= 1'b0;
      end else if (sclr) begin
         cor_xin <= '0;
         cor_yin <= '0;
         res_ch  <= '0;
         res_mag <= '0;
         res_ph  <= '0;
         res_vld <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: if (req_any) begin
               cor_xin <= xa[gidx];
               cor_yin <= ya[gidx];
               res_ch  <= gidx;
            end
            BUSY: if (cor_rdy) begin
               res_mag <= cor_mag;
               res_ph  <= cor_ph;
               res_vld <= 1'b1;
            end else if (tmo) begin
               res_mag <= '0;
               res_ph  <= '0;
               res_vld <= 1'b1;
            end
            HOLD: if (res_rdy) res_vld <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_mag_ph_sched.sv
// Randomized bench for cordic_mag_ph_sched with a transaction-timing reference
// model and a behavioural core that answers N+2 clocks after cor_st.
module tb_cordic_mag_ph_sched;

   localparam int NCH = 4;
   localparam int N   = 13;
   localparam int W   = 18;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              reset, sclr, en, res_rdy, cor_rdy;
   logic [NCH-1:0]    req_vld, req_rdy;
   logic [NCH*W-1:0]  req_x, req_y;
   logic              cor_st, res_vld, res_err, busy;
   logic [W-1:0]      cor_xin, cor_yin, cor_mag, res_mag;
   logic [W+1:0]      cor_ph, res_ph;
   logic [CW-1:0]     res_ch;

   cordic_mag_ph_sched #(.NCH(NCH), .N(N), .XY_WDT(W)) dut (
      .clk(clk), .reset(reset), .sclr(sclr), .en(en),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x), .req_y(req_y),
      .cor_st(cor_st), .cor_xin(cor_xin), .cor_yin(cor_yin),
      .cor_rdy(cor_rdy), .cor_mag(cor_mag), .cor_ph(cor_ph),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_ch(res_ch),
      .res_mag(res_mag), .res_ph(res_ph), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [NCH-1:0] pend;
   bit             sticky, rnd_xy, core_never;
   logic [W-1:0]   xs [NCH];
   logic [W-1:0]   ys [NCH];

   int             core_cnt;
   logic [W-1:0]   core_x, core_y;

   // reference: one outstanding transaction, its grant cycle and result cycle
   bit             m_out, m_err;
   int             m_ptr, m_g, m_ch, m_res;
   logic [W-1:0]   m_x, m_y;

   function automatic logic [W-1:0] fmag(input logic [W-1:0] x, input logic [W-1:0] y);
      return x + (y << 1) + W'(341);
   endfunction

   function automatic logic [W+1:0] fph(input logic [W-1:0] x, input logic [W-1:0] y);
      return {x, 2'b10} ^ {2'b00, y};
   endfunction

   function automatic int pick(input logic [NCH-1:0] v, input int p);
      for (int i = 0; i < NCH; i++) begin
         int k = (p + i) % NCH;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string t);
      chk({t, ".req_rdy"}, 32'(req_rdy), 32'd0);
      chk({t, ".cor_st"},  32'(cor_st),  32'd0);
      chk({t, ".cor_xin"}, 32'(cor_xin), 32'd0);
      chk({t, ".cor_yin"}, 32'(cor_yin), 32'd0);
      chk({t, ".res_vld"}, 32'(res_vld), 32'd0);
      chk({t, ".res_ch"},  32'(res_ch),  32'd0);
      chk({t, ".res_mag"}, 32'(res_mag), 32'd0);
      chk({t, ".res_ph"},  32'(res_ph),  32'd0);
      chk({t, ".res_err"}, 32'(res_err), 32'd0);
      chk({t, ".busy"},    32'(busy),    32'd0);
   endtask

   // one clock: drive after the rising edge, check and advance model at the falling edge
   task automatic step(input bit en_i, input bit sclr_i, input bit rdy_i);
      int g;
      bit ev, est;
      @(posedge clk); #1;
      cyc++;
      en      = en_i;
      sclr    = sclr_i;
      res_rdy = rdy_i;
      req_vld = pend;
      for (int i = 0; i < NCH; i++) begin
         if (rnd_xy) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
         end
         req_x[i*W +: W] = xs[i];
         req_y[i*W +: W] = ys[i];
      end
      cor_rdy = 1'b0;
      cor_mag = W'($urandom);
      cor_ph  = (W+2)'($urandom);
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0 && !core_never) begin
            cor_rdy = 1'b1;
            cor_mag = fmag(core_x, core_y);
            cor_ph  = fph(core_x, core_y);
         end
      end
      @(negedge clk);
      g   = (!m_out && en_i && !sclr_i) ? pick(req_vld, m_ptr) : -1;
      ev  = m_out && (cyc >= m_res);
      est = m_out && en_i && !sclr_i && (cyc == m_g + 1);
      chk("req_rdy", 32'(req_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("cor_st",  32'(cor_st),  32'(est));
      chk("res_vld", 32'(res_vld), 32'(ev));
      chk("busy",    32'(busy),    32'(m_out));
      if (est) begin
         chk("cor_xin", 32'(cor_xin), 32'(m_x));
         chk("cor_yin", 32'(cor_yin), 32'(m_y));
      end
      if (ev) begin
         chk("res_ch",  32'(res_ch),  32'(m_ch));
         chk("res_mag", 32'(res_mag), m_err ? 32'd0 : 32'(fmag(m_x, m_y)));
         chk("res_ph",  32'(res_ph),  m_err ? 32'd0 : 32'(fph(m_x, m_y)));
         chk("res_err", 32'(res_err), 32'(m_err));
      end
      if (cor_st) begin
         core_cnt = N + 2;
         core_x   = cor_xin;
         core_y   = cor_yin;
      end
      if (sclr_i) begin
         m_out = 1'b0;
         m_ptr = 0;
      end else if (en_i) begin
         if (g >= 0) begin
            m_out = 1'b1;
            m_g   = cyc;
            m_ch  = g;
            m_x   = xs[g];
            m_y   = ys[g];
            m_ptr = (g + 1) % NCH;
            m_err = core_never;
            m_res = cyc + N + (core_never ? 6 : 4);
            if (!sticky) pend[g] = 1'b0;
         end else if (ev && rdy_i) begin
            m_out = 1'b0;
         end
      end
   endtask

   task automatic drain();
      pend = '0;
      repeat (30) step(1'b1, 1'b0, 1'b1);
   endtask

   int hv;

   initial begin
      reset = 1'b1; sclr = 1'b0; en = 1'b1; res_rdy = 1'b1;
      cor_rdy = 1'b0; cor_mag = '0; cor_ph = '0;
      req_vld = '0; req_x = '0; req_y = '0;
      pend = '0; sticky = 1'b0; rnd_xy = 1'b0; core_never = 1'b0; core_cnt = 0;
      m_out = 1'b0; m_err = 1'b0; m_ptr = 0; m_g = 0; m_ch = 0; m_res = 0;
      m_x = '0; m_y = '0; core_x = '0; core_y = '0;
      for (int i = 0; i < NCH; i++) begin xs[i] = '0; ys[i] = '0; end
      repeat (2) @(negedge clk);
      chk_zero("rst");
      reset = 1'b0;

      // single request on channel 2 with a fixed operand
      xs[2] = 18'h0C000;
      pend  = 4'b0100;
      repeat (22) step(1'b1, 1'b0, 1'b1);
      rnd_xy = 1'b1;

      // all channels held valid: clear the pointer first, then 0,1,2,3,0
      step(1'b1, 1'b1, 1'b1);
      sticky = 1'b1;
      pend   = 4'hF;
      repeat (92) step(1'b1, 1'b0, 1'b1);
      sticky = 1'b0;
      drain();

      // result backpressure for 10 valid cycles while others wait
      pend = 4'b0001;
      hv   = 0;
      for (int c = 0; c < 50; c++) begin
         step(1'b1, 1'b0, hv >= 10);
         if (res_vld) hv++;
         if (c == 2) pend = 4'b0110;
      end
      drain();

      // clock enable low in IDLE with requests pending
      pend = 4'b1001;
      repeat (3) step(1'b0, 1'b0, 1'b1);
      repeat (45) step(1'b1, 1'b0, 1'b1);
      drain();

      // async reset in the middle of BUSY, then a late core strobe
      pend = 4'b0001;
      repeat (6) step(1'b1, 1'b0, 1'b1);
      #1 reset = 1'b1;
      #1 chk_zero("arst");
      #1 reset = 1'b0;
      m_out = 1'b0;
      m_ptr = 0;
      pend  = '0;
      repeat (20) step(1'b1, 1'b0, 1'b1);
      pend = 4'b1010;
      repeat (45) step(1'b1, 1'b0, 1'b1);

      // sync clear in BUSY
      pend = 4'b0100;
      repeat (6) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      pend = '0;
      repeat (20) step(1'b1, 1'b0, 1'b1);
      pend = 4'b0011;
      repeat (45) step(1'b1, 1'b0, 1'b1);

      // random traffic, random drops before grant, random sink stalls
      for (int c = 0; c < 700; c++) begin
         if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, NCH-1)] = 1'b1;
         if ($urandom_range(0, 15) == 0) pend[$urandom_range(0, NCH-1)] = 1'b0;
         step(1'b1, 1'b0, $urandom_range(0, 3) != 0);
      end
      drain();

`ifdef CORDIC_MAG_PH_SCHED_TIMEOUT_EN
      // core never answers: error result N+6 after accept, then normal service
      core_never = 1'b1;
      pend = 4'b0010;
      repeat (24) step(1'b1, 1'b0, 1'b1);
      core_never = 1'b0;
      pend = 4'b0010;
      repeat (24) step(1'b1, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cordic_mag_ph_sched.md
Name: cordic_mag_ph_sched

Overview:
Round-robin scheduler that shares one serial CORDIC magnitude/phase core among NCH requesters. Each channel offers one (x, y) sample with a valid/ready handshake. The scheduler launches the core, waits for its ready strobe, and returns mag/ph tagged with the channel index over a valid/ready result port. The core sits outside this block and connects through the cor_* ports.

Parameters:
NCH, 4, number of requesting channels (2..16)
N, 13, core iteration count; core latency is N+2 clocks from cor_st to cor_rdy
XY_WDT, 18, width of x/y samples and of mag; ph is XY_WDT+2
CH_WDT, $clog2(NCH), width of channel index (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  async reset, active-high
sclr  in  1  sync clear
en  in  1  clock enable
req_vld  in  NCH  per-channel request valid
req_rdy  out  NCH  per-channel accept strobe (one-hot or zero)
req_x  in  NCH*XY_WDT  packed signed x, channel k at [k*XY_WDT +: XY_WDT]
req_y  in  NCH*XY_WDT  packed signed y, same packing
cor_st  out  1  core start pulse
cor_xin  out  XY_WDT  core x operand
cor_yin  out  XY_WDT  core y operand
cor_rdy  in  1  core result strobe
cor_mag  in  XY_WDT  core magnitude, unsigned
cor_ph  in  XY_WDT+2  core phase, signed
res_vld  out  1  result valid
res_rdy  in  1  result accepted by sink
res_ch  out  CH_WDT  channel that produced the result
res_mag  out  XY_WDT  registered magnitude
res_ph  out  XY_WDT+2  registered phase
res_err  out  1  result aborted (timeout only)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async) and sclr (sync, priority over en) force: state IDLE, RR pointer 0, req_rdy 0, cor_st 0, cor_xin/yin 0, res_vld 0, res_ch/mag/ph 0, res_err 0, busy 0. sclr mid-operation abandons the operation. A cor_rdy arriving afterwards in IDLE is ignored.
- en low freezes all registers. req_rdy and cor_st are forced to 0 while en is low. A freeze in BUSY may cause the core's strobe to be missed. The integrator must gate the core with the same en.
- FSM states: IDLE, START, BUSY, HOLD.
- IDLE: if any req_vld is high, the arbiter picks the first set bit at or after the pointer, wrapping modulo NCH. In the same cycle: req_rdy[g]=1, latch req_x/req_y[g] into cor_xin/yin, latch g into res_ch, pointer <= (g+1) mod NCH, go to START.
- START: cor_st=1 for exactly one cycle, then BUSY.
- BUSY: on cor_rdy, register cor_mag/cor_ph into res_mag/res_ph, set res_vld=1, go to HOLD.
- HOLD: res_vld and res_* are held stable until res_rdy is high. On that cycle res_vld drops next clock and the state returns to IDLE. There is no request acceptance in HOLD.
- Latency: accept at cycle 0, cor_st at cycle 1, cor_rdy at cycle N+3, res_vld at cycle N+4 (cycle 17 for N=13). Minimum issue interval is N+5 cycles with res_rdy tied high.
- Fairness: each channel holding req_vld continuously is served within NCH grants.
- req_vld dropping before its grant: no effect and no latching.
- cor_rdy while not in BUSY is ignored.

Optional Feature:
- Macro CORDIC_MAG_PH_SCHED_TIMEOUT_EN.
- Defined: a BUSY watchdog counts cycles. If cor_rdy is not seen within N+4 cycles, go to HOLD with res_vld=1, res_err=1, res_mag=0, res_ph=0, and the granted res_ch. res_err clears when the result is accepted.
- Undefined: no counter; res_err is tied 0 and BUSY waits indefinitely.

Decomposition:
- Package cordic_sched_pkg: state enum (IDLE, START, BUSY, HOLD), localparam core latency N+2, function computing CH_WDT.
- Sub-module cordic_rr_arb (NCH): inputs req vector, pointer, and grant-enable; outputs one-hot grant, encoded index, and any-request flag. Purely combinational plus pointer register.

Test Plan:
- Single request: NCH=4, N=13, ch2 x=0x0C000, y=0 -> req_rdy[2] at cycle 0, cor_st at cycle 1, res_vld at cycle 17 with res_ch=2 and res_mag/res_ph equal to the model core output.
- All four channels valid continuously, res_rdy=1 -> grant order 0,1,2,3,0; each grant 18 cycles apart.
- Backpressure: res_rdy low for 10 cycles after res_vld -> res_* stable, no req_rdy pulse, and the next grant in the cycle after acceptance plus one.
- Async reset during BUSY -> all outputs 0 immediately. A late cor_rdy produces no res_vld, and the pointer restarts at 0.
- en toggled low for 3 cycles in IDLE with pending requests -> no req_rdy and no state change. Resumes correctly when en returns high.
- With TIMEOUT_EN, core model never asserts cor_rdy -> res_vld with res_err=1 at cycle N+6 after accept. Next request is served normally.
